// File: rtl/pe_drain.sv
// pe_drain: output collector at the bottom of one PE-array column.
// Requantises ACC_BW accumulator words to MUL_BW fixed point (saturating),
// buffers them in a DEPTH-entry FIFO and presents them on a valid/ready stream.
// Optional feature: define PE_DRAIN_RND_EN to round half-up instead of floor.
module pe_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 9,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [ACC_BW-1:0]      o_i,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [MUL_BW-1:0]      out_data,
    output logic [$clog2(DEPTH):0] cnt,
    output logic [15:0]            sat_cnt,
    output logic                   ovf,
    input  logic                   clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time guard against parameter sets the datapath cannot handle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || INT_BW < 0 || FRA_BW < 2 ||
        MUL_BW + FRA_BW > ACC_BW) begin : g_bad_params
        $error("pe_drain: unsupported parameter set");
    end

    // ---------------------------------------------------------------
    // Stage 1: shift (floor or round-half-up) then saturate
    // ---------------------------------------------------------------
`ifdef PE_DRAIN_RND_EN
    // One extra bit so adding the half-LSB can never wrap the accumulator.
    localparam int TW = ACC_BW + 1;
    localparam logic [TW-1:0] RND_HALF = {{(TW-FRA_BW){1'b0}}, 1'b1, {(FRA_BW-1){1'b0}}};
    logic [TW-1:0]        rnd_sum;
    logic signed [TW-1:0] t_shift;
    assign rnd_sum = {o_i[ACC_BW-1], o_i} + RND_HALF;
    assign t_shift = $signed(rnd_sum) >>> FRA_BW;
`else
    localparam int TW = ACC_BW;
    logic signed [TW-1:0] t_shift;
    assign t_shift = $signed(o_i) >>> FRA_BW;
`endif

    localparam logic signed [TW-1:0] SAT_HI = {{(TW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
    localparam logic signed [TW-1:0] SAT_LO = {{(TW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

    logic [MUL_BW-1:0] s1_data_d, s1_data_q;
    logic              s1_sat_d, s1_sat_q;
    logic              s1_vld_q;

    // Clamp the shifted value to the signed MUL_BW range, flagging saturation.
    always_comb begin
        s1_sat_d  = 1'b0;
        s1_data_d = t_shift[MUL_BW-1:0];
        if (t_shift > SAT_HI) begin
            s1_sat_d  = 1'b1;
            s1_data_d = {1'b0, {(MUL_BW-1){1'b1}}};
        end else if (t_shift < SAT_LO) begin
            s1_sat_d  = 1'b1;
            s1_data_d = {1'b1, {(MUL_BW-1){1'b0}}};
        end
    end

    // Stage-1 pipeline register; the array never stalls, so it loads every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_sat_q  <= 1'b0;
        end else begin
            s1_vld_q  <= in_vld;
            s1_data_q <= s1_data_d;
            s1_sat_q  <= s1_sat_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: FIFO
    // ---------------------------------------------------------------
    logic [MUL_BW-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MUL_BW-1:0] head_q, head_d;
    logic              pop, full, wr_en, drop;

    // Pointer/occupancy bookkeeping and next head word.
    always_comb begin
        pop    = (cnt_q != '0) && out_rdy;
        full   = (cnt_q == CW'(DEPTH));
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        wr_en  = s1_vld_q && (!full || pop);
        drop   = s1_vld_q && full && !pop;
        wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop   ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
        // Head is a registered read; it holds its last value when empty.
        head_d = head_q;
        if (cnt_d != '0) begin
            // Nothing left after the pop: the only entry is the one being written.
            if (cnt_q == CW'(pop)) head_d = s1_data_q;
            else                   head_d = mem_q[rptr_d];
        end
    end

    // FIFO storage: written only, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= s1_data_q;
    end

    // FIFO control state and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    // ---------------------------------------------------------------
    // Status: saturation counter and sticky overflow; clr wins over events
    // ---------------------------------------------------------------
    logic [15:0] sat_cnt_q;
    logic        ovf_q;

    // Count saturated words (written or dropped) and latch any drop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sat_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (s1_vld_q && s1_sat_q && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign out_vld  = (cnt_q != '0);
    assign out_data = head_q;
    assign cnt      = cnt_q;
    assign sat_cnt  = sat_cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_pe_drain.sv
// Testbench for pe_drain: directed scenarios plus a randomized run checked
// against a queue-based reference model of the collector.
module tb_pe_drain;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, in_vld, out_rdy, clr;
    logic [31:0] o_i;
    logic        out_vld, ovf;
    logic [15:0] out_data, sat_cnt;
    logic [3:0]  cnt;

    always #5 clk = ~clk;

    pe_drain dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .o_i(o_i),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .cnt(cnt), .sat_cnt(sat_cnt), .ovf(ovf), .clr(clr)
    );

    int n_vec = 0;
    int n_err = 0;

`ifdef PE_DRAIN_RND_EN
    localparam logic [15:0] EXP_NEG1 = 16'h0000;
    localparam logic [15:0] EXP_HALF = 16'h0001;
`else
    localparam logic [15:0] EXP_NEG1 = 16'hFFFF;
    localparam logic [15:0] EXP_HALF = 16'h0000;
`endif

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_s1_vld = 1'b0;
    logic [15:0] m_s1_word = '0;
    logic        m_s1_sat = 1'b0;
    int          m_sat = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_last = '0;

    // Requantise with plain integer arithmetic: {sat, word}
    function automatic logic [16:0] requant(input logic [31:0] w);
        longint v;
        longint t;
        v = longint'($signed(w));
`ifdef PE_DRAIN_RND_EN
        v = v + 256;
`endif
        t = v >>> 9;
        if (t > 32767)       return {1'b1, 16'h7FFF};
        else if (t < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(t)};
    endfunction

    // Drive one cycle of inputs, advance the model, land 1ns after the edge.
    task automatic tick(input logic vld, input logic [31:0] d, input logic rdy,
                        input logic c, input logic r);
        logic [16:0] rq;
        in_vld = vld; o_i = d; out_rdy = rdy; clr = c; rst = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_s1_vld = 1'b0; m_sat = 0; m_ovf = 1'b0; m_last = '0;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_s1_vld) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_s1_word);
                else                    m_ovf = 1'b1;
                if (m_s1_sat && m_sat < 65535) m_sat++;
            end
            if (c) begin m_sat = 0; m_ovf = 1'b0; end
            rq = requant(d);
            m_s1_vld = vld; m_s1_word = rq[15:0]; m_s1_sat = rq[16];
        end
        if (m_q.size() != 0) m_last = m_q[0];
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        n_vec++; if (out_vld !== 1'b0)   begin n_err++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        n_vec++; if (cnt !== 4'd0)       begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        n_vec++; if (sat_cnt !== 16'h0)  begin n_err++; $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
        n_vec++; if (ovf !== 1'b0)       begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        tick(1, 32'h0000_0200, 0, 0, 0);
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL lat_early_vld got %b want 0", out_vld); end
        tick(0, 0, 0, 0, 0);
        n_vec++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL lat_vld got %b want 1", out_vld); end
        n_vec++; if (out_data !== 16'h0001) begin n_err++; $display("FAIL lat_data got %h want 0001", out_data); end
        n_vec++; if (cnt !== 4'd1)          begin n_err++; $display("FAIL lat_cnt got %0d want 1", cnt); end
        tick(0, 0, 1, 0, 0);
        n_vec++; if (cnt !== 4'd0)          begin n_err++; $display("FAIL lat_pop_cnt got %0d want 0", cnt); end
        n_vec++; if (out_data !== 16'h0001) begin n_err++; $display("FAIL lat_hold got %h want 0001", out_data); end
        $display("test_latency done");
    endtask

    task automatic test_saturation();
        tick(1, 32'h7FFF_FFFF, 0, 0, 0);
        tick(1, 32'h8000_0000, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_vec++; if (out_data !== 16'h7FFF) begin n_err++; $display("FAIL sat_hi got %h want 7fff", out_data); end
        n_vec++; if (sat_cnt !== 16'd2)     begin n_err++; $display("FAIL sat_cnt got %0d want 2", sat_cnt); end
        tick(0, 0, 1, 0, 0);
        n_vec++; if (out_data !== 16'h8000) begin n_err++; $display("FAIL sat_lo got %h want 8000", out_data); end
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        n_vec++; if (sat_cnt !== 16'd0)     begin n_err++; $display("FAIL sat_clr got %0d want 0", sat_cnt); end
        tick(1, 32'h7FFF_FFFF, 1, 0, 0);
        tick(0, 0, 1, 1, 0);
        n_vec++; if (sat_cnt !== 16'd0)     begin n_err++; $display("FAIL sat_clr_wins got %0d want 0", sat_cnt); end
        tick(0, 0, 1, 0, 0);
        n_vec++; if (cnt !== 4'd0)          begin n_err++; $display("FAIL sat_drain_cnt got %0d want 0", cnt); end
        $display("test_saturation done");
    endtask

    task automatic test_rounding();
        tick(1, 32'hFFFF_FFFF, 1, 0, 0);
        tick(1, 32'h0000_0100, 1, 0, 0);
        n_vec++; if (out_data !== EXP_NEG1) begin n_err++; $display("FAIL rnd_neg1 got %h want %h", out_data, EXP_NEG1); end
        tick(0, 0, 1, 0, 0);
        n_vec++; if (out_data !== EXP_HALF) begin n_err++; $display("FAIL rnd_half got %h want %h", out_data, EXP_HALF); end
        tick(0, 0, 1, 0, 0);
        $display("test_rounding done");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) tick(1, 32'(i) << 9, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_vec++; if (cnt !== 4'd8) begin n_err++; $display("FAIL ovf_cnt got %0d want 8", cnt); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
        for (int i = 1; i <= 8; i++) begin
            n_vec++; if (out_data !== 16'(i)) begin n_err++; $display("FAIL ovf_drain got %h want %h", out_data, 16'(i)); end
            tick(0, 0, 1, 0, 0);
        end
        n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b want 0", out_vld); end
        tick(0, 0, 0, 1, 0);
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", ovf); end
        $display("test_overflow done");
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 9; k++) tick(1, 32'(200 + k) << 9, 0, 0, 0);
        n_vec++; if (cnt !== 4'd8) begin n_err++; $display("FAIL full_fill got %0d want 8", cnt); end
        for (int j = 1; j <= 20; j++) begin
            tick(1, 32'(208 + j) << 9, 1, 0, 0);
            n_vec++; if (cnt !== 4'd8)              begin n_err++; $display("FAIL full_cnt got %0d want 8", cnt); end
            n_vec++; if (ovf !== 1'b0)              begin n_err++; $display("FAIL full_ovf got %b want 0", ovf); end
            n_vec++; if (out_data !== 16'(200 + j)) begin n_err++; $display("FAIL full_order got %h want %h", out_data, 16'(200 + j)); end
        end
        for (int j = 0; j < 10; j++) tick(0, 0, 1, 0, 0);
        n_vec++; if (cnt !== 4'd0) begin n_err++; $display("FAIL full_drain got %0d want 0", cnt); end
        $display("test_full_pop done");
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 4; k++) tick(1, 32'(300 + k) << 9, 0, 0, 0);
        n_vec++; if (cnt !== 4'd3) begin n_err++; $display("FAIL mid_cnt got %0d want 3", cnt); end
        tick(1, 32'h0001_0000, 0, 0, 1);
        n_vec++; if (cnt !== 4'd0)       begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", cnt); end
        n_vec++; if (out_vld !== 1'b0)   begin n_err++; $display("FAIL mid_rst_vld got %b want 0", out_vld); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0000", out_data); end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 1, 0, 0);
            n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL mid_stale got %b want 0", out_vld); end
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'(int'($urandom_range(0, 1 << 25)) - (1 << 24));
                2:       d = 32'h00FF_FE00 + 32'($urandom_range(0, 1023)) - 32'd512;
                default: d = 32'hFF00_0000 + 32'($urandom_range(0, 1023)) - 32'd512;
            endcase
            tick(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 149) == 0));
            n_vec++; if (out_vld !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_vld cyc %0d got %b want %b", n, out_vld, (m_q.size() != 0)); end
            n_vec++; if (cnt !== 4'(m_q.size()))        begin n_err++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, cnt, m_q.size()); end
            n_vec++; if (out_data !== m_last)           begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", n, out_data, m_last); end
            n_vec++; if (sat_cnt !== 16'(m_sat))        begin n_err++; $display("FAIL rnd_sat cyc %0d got %0d want %0d", n, sat_cnt, m_sat); end
            n_vec++; if (ovf !== m_ovf)                 begin n_err++; $display("FAIL rnd_ovf cyc %0d got %b want %b", n, ovf, m_ovf); end
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; clr = 1'b0; o_i = '0;
        test_reset();
        test_latency();
        test_saturation();
        test_rounding();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
